// File: rtl/wd33c93_host_responder.sv
// WD33C93 host-bus responder: indirect register file, 24-bit transfer counter, byte FIFO and DREQ_.
// Build option: define WD_ADDR_AUTOINC_EN to post-increment ADDR on data-register accesses.
module wd33c93_host_responder #(
  parameter int FIFO_DEPTH = 12
) (
  input  logic       CPUCLK,
  input  logic       RESET,
  input  logic       SCSI_CS,
  input  logic       RE,
  input  logic       WE,
  input  logic       DACK,
  input  logic       A0,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  output logic       DREQ_,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY
);
  // state    | meaning
  // IDLE     | waiting for a start command
  // XFER_IN  | target->host: TX fills FIFO, DMA reads drain it
  // XFER_OUT | host->target: DMA writes fill FIFO, RX drains it
  // DONE     | one cycle: post status, raise INT, flush FIFO

`ifdef WD_ADDR_AUTOINC_EN
  localparam logic ADDR_AUTOINC = 1'b1;
`else
  localparam logic ADDR_AUTOINC = 1'b0;
`endif

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [4:0] A_TC_HI  = 5'h12;
  localparam logic [4:0] A_TC_MID = 5'h13;
  localparam logic [4:0] A_TC_LO  = 5'h14;
  localparam logic [4:0] A_STATUS = 5'h17;
  localparam logic [4:0] A_CMD    = 5'h18;

  typedef enum logic [1:0] {IDLE, XFER_IN, XFER_OUT, DONE} state_t;

  state_t          state;
  logic [7:0]      regs [0:31];
  logic [4:0]      addr;
  logic [23:0]     tc;
  logic            int_q;
  logic [7:0]      fifo [0:FIFO_DEPTH-1];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic re_q, we_q, cs_q, dack_q, a0_q;
  logic re_p, we_p, cs_p, dack_p, a0_p;
  logic [7:0] din_q, din_p;

  logic re_fall, we_fall, re_rise, dma_rd, dma_wr, reg_rd, reg_wr;
  logic full, empty, bsy, push, pop, start_cmd;
  logic [7:0] push_data, aux;
  logic [23:0] tc_cfg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Falls are judged on the previous registered sample so CS/DACK/A0/DIN are those seen during the strobe.
  assign re_fall   = re_p & ~re_q & ~we_p;
  assign we_fall   = we_p & ~we_q & ~re_p;
  assign re_rise   = re_q & ~re_p;
  assign dma_rd    = re_fall & dack_p;
  assign dma_wr    = we_fall & dack_p;
  assign reg_rd    = re_fall & cs_p & ~dack_p;
  assign reg_wr    = we_fall & cs_p & ~dack_p;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign bsy       = (state != IDLE);
  assign start_cmd = (din_p[7:1] == 7'b0010000);
  assign tc_cfg    = {regs[A_TC_HI], regs[A_TC_MID], regs[A_TC_LO]};
  assign aux       = {int_q, 5'b0, bsy, ~DREQ_};
  assign DOE       = re_q & (cs_q | dack_q);
  assign TX_READY  = (state == XFER_IN) & ~full;
  assign RX_VALID  = (state == XFER_OUT) & ~empty;
  assign RX_DATA   = fifo[rd_ptr];

  always_comb begin
    DREQ_     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = 8'h00;
    case (state)
      XFER_IN: begin
        DREQ_     = ~(~empty & (tc != '0));
        push      = TX_VALID & ~full;
        push_data = TX_DATA;
        pop       = dma_rd & ~empty;
      end
      XFER_OUT: begin
        DREQ_     = ~(~full & (tc != '0));
        push      = dma_wr & ~full;
        push_data = din_p;
        pop       = ~empty & RX_READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      {re_q, we_q, cs_q, dack_q, a0_q} <= '0;
      {re_p, we_p, cs_p, dack_p, a0_p} <= '0;
      din_q <= '0;
      din_p <= '0;
    end else begin
      {re_q, we_q, cs_q, dack_q, a0_q} <= {RE, WE, SCSI_CS, DACK, A0};
      {re_p, we_p, cs_p, dack_p, a0_p} <= {re_q, we_q, cs_q, dack_q, a0_q};
      din_q <= DIN;
      din_p <= din_q;
    end
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      state  <= IDLE;
      addr   <= '0;
      tc     <= '0;
      int_q  <= 1'b0;
      DOUT   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (re_rise) begin
        if (dack_q)
          DOUT <= (state == XFER_IN && !empty) ? fifo[rd_ptr] : 8'hFF;
        else if (cs_q)
          DOUT <= a0_q ? regs[addr] : aux;
      end

      if (push) begin
        fifo[wr_ptr] <= push_data;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (reg_wr && !a0_p) addr <= din_p[4:0];
      if (reg_wr && a0_p) begin
        if (addr == A_CMD && start_cmd) begin
          if (state == IDLE) begin
            regs[A_CMD] <= din_p;
            tc          <= tc_cfg;
            if (tc_cfg == '0) state <= DONE;
            else              state <= din_p[0] ? XFER_OUT : XFER_IN;
          end else begin
            regs[A_STATUS] <= 8'h05;
            int_q          <= 1'b1;
          end
        end else begin
          regs[addr] <= din_p;
        end
      end
      if (reg_rd && a0_p && addr == A_STATUS) int_q <= 1'b0;
      if (ADDR_AUTOINC && (reg_wr || reg_rd) && a0_p && addr != A_CMD) addr <= addr + 5'd1;

      if (((dma_rd && state == XFER_IN) || (dma_wr && state == XFER_OUT)) && tc != '0)
        tc <= tc - 24'd1;

      case (state)
        XFER_IN:  if (tc == '0) state <= DONE;
        XFER_OUT: if (tc == '0 && empty) state <= DONE;
        DONE: begin
          regs[A_STATUS] <= 8'h16;
          int_q          <= 1'b1;
          rd_ptr         <= '0;
          wr_ptr         <= '0;
          count          <= '0;
          state          <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wd33c93_host_responder.sv
// Directed self-checking bench for wd33c93_host_responder; expectations follow WD_ADDR_AUTOINC_EN.
module tb_wd33c93_host_responder;
  logic       CPUCLK = 1'b0;
  logic       RESET = 1'b1, SCSI_CS = 1'b0, RE = 1'b0, WE = 1'b0, DACK = 1'b0, A0 = 1'b0;
  logic [7:0] DIN = 8'h00, TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0, RX_READY = 1'b0;
  logic [7:0] DOUT, RX_DATA;
  logic       DOE, DREQ_, TX_READY, RX_VALID;

  int checks = 0;
  int failures = 0;

  wd33c93_host_responder #(.FIFO_DEPTH(12)) dut (
    .CPUCLK(CPUCLK), .RESET(RESET), .SCSI_CS(SCSI_CS), .RE(RE), .WE(WE), .DACK(DACK),
    .A0(A0), .DIN(DIN), .DOUT(DOUT), .DOE(DOE), .DREQ_(DREQ_),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
  );

  always #5 CPUCLK = ~CPUCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CPUCLK);
    #1;
  endtask

  task automatic bus_write(input logic dma, input logic a0, input logic [7:0] d);
    SCSI_CS = ~dma; DACK = dma; A0 = a0; DIN = d; WE = 1'b1;
    tick(2);
    WE = 1'b0;
    tick(3);
    SCSI_CS = 1'b0; DACK = 1'b0; A0 = 1'b0;
    tick(1);
  endtask

  task automatic bus_read(input logic dma, input logic a0, output logic [7:0] d, output logic doe);
    SCSI_CS = ~dma; DACK = dma; A0 = a0; RE = 1'b1;
    tick(3);
    d = DOUT; doe = DOE;
    RE = 1'b0;
    tick(3);
    SCSI_CS = 1'b0; DACK = 1'b0; A0 = 1'b0;
    tick(1);
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
    bus_write(1'b0, 1'b0, {3'b000, a});
    bus_write(1'b0, 1'b1, d);
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [7:0] d);
    logic doe;
    bus_write(1'b0, 1'b0, {3'b000, a});
    bus_read(1'b0, 1'b1, d, doe);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic doe;
    logic [4:0] addrs [7] = '{5'h00, 5'h05, 5'h12, 5'h13, 5'h14, 5'h17, 5'h1F};
    SCSI_CS = 0; RE = 0; WE = 0; DACK = 0; TX_VALID = 0; RX_READY = 0;
    do_reset();
    checks++; if (DREQ_ !== 1'b1) begin failures++; $display("FAIL reset_dreq got=%b exp=1", DREQ_); end
    checks++; if (DOE !== 1'b0) begin failures++; $display("FAIL reset_doe got=%b exp=0", DOE); end
    checks++; if (DOUT !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
    checks++; if (TX_READY !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", TX_READY); end
    checks++; if (RX_VALID !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", RX_VALID); end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_aux got=%h exp=00", d); end
    checks++; if (doe !== 1'b1) begin failures++; $display("FAIL read_doe got=%b exp=1", doe); end
    checks++; if (DOE !== 1'b0) begin failures++; $display("FAIL idle_doe got=%b exp=0", DOE); end
    foreach (addrs[i]) begin
      reg_rd(addrs[i], d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_reg_%h got=%h exp=00", addrs[i], d); end
    end
  endtask

  task automatic test_reg_io();
    logic [7:0] d;
    logic doe;
`ifdef WD_ADDR_AUTOINC_EN
    logic [7:0] exp [3] = '{8'h00, 8'h00, 8'h03};
`else
    logic [7:0] exp [3] = '{8'h03, 8'h03, 8'h03};
`endif
    bus_write(1'b0, 1'b0, 8'h12);
    bus_write(1'b0, 1'b1, 8'h00);
    bus_write(1'b0, 1'b1, 8'h00);
    bus_write(1'b0, 1'b1, 8'h03);
    bus_write(1'b0, 1'b0, 8'h12);
    for (int i = 0; i < 3; i++) begin
      bus_read(1'b0, 1'b1, d, doe);
      checks++;
      if (d !== exp[i]) begin failures++; $display("FAIL regio_read%0d got=%h exp=%h", i, d, exp[i]); end
    end
  endtask

  task automatic test_dma_in();
    logic [7:0] d;
    logic doe;
    logic [7:0] bytes [3] = '{8'hA1, 8'hB2, 8'hC3};
    reg_wr(5'h12, 8'h00);
    reg_wr(5'h13, 8'h00);
    reg_wr(5'h14, 8'h03);
    reg_wr(5'h18, 8'h20);
    checks++; if (DREQ_ !== 1'b1) begin failures++; $display("FAIL din_dreq_empty got=%b exp=1", DREQ_); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TX_READY !== 1'b1) begin failures++; $display("FAIL din_tx_ready%0d got=%b exp=1", i, TX_READY); end
      TX_DATA = bytes[i]; TX_VALID = 1'b1;
      tick(1);
    end
    TX_VALID = 1'b0;
    checks++; if (DREQ_ !== 1'b0) begin failures++; $display("FAIL din_dreq_filled got=%b exp=0", DREQ_); end
    for (int i = 0; i < 3; i++) begin
      bus_read(1'b1, 1'b0, d, doe);
      checks++;
      if (d !== bytes[i]) begin failures++; $display("FAIL din_byte%0d got=%h exp=%h", i, d, bytes[i]); end
      checks++;
      if (DREQ_ !== (i == 2)) begin failures++; $display("FAIL din_dreq_after%0d got=%b exp=%b", i, DREQ_, (i == 2)); end
    end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL din_aux_int got=%h exp=80", d); end
    reg_rd(5'h17, d);
    checks++; if (d !== 8'h16) begin failures++; $display("FAIL din_status got=%h exp=16", d); end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL din_aux_clear got=%h exp=00", d); end
  endtask

  task automatic test_dma_out();
    logic [7:0] d;
    logic doe;
    logic [7:0] bytes [2] = '{8'h55, 8'hAA};
    int got;
    reg_wr(5'h12, 8'h00);
    reg_wr(5'h13, 8'h00);
    reg_wr(5'h14, 8'h02);
    RX_READY = 1'b0;
    reg_wr(5'h18, 8'h21);
    checks++; if (DREQ_ !== 1'b0) begin failures++; $display("FAIL dout_dreq_start got=%b exp=0", DREQ_); end
    checks++; if (RX_VALID !== 1'b0) begin failures++; $display("FAIL dout_rx_valid_empty got=%b exp=0", RX_VALID); end
    for (int i = 0; i < 2; i++) begin
      bus_write(1'b1, 1'b0, bytes[i]);
      checks++;
      if (DREQ_ !== (i == 1)) begin failures++; $display("FAIL dout_dreq_after%0d got=%b exp=%b", i, DREQ_, (i == 1)); end
    end
    checks++; if (RX_VALID !== 1'b1) begin failures++; $display("FAIL dout_rx_valid got=%b exp=1", RX_VALID); end
    RX_READY = 1'b1;
    got = 0;
    for (int n = 0; n < 10 && got < 2; n++) begin
      if (RX_VALID) begin
        checks++;
        if (RX_DATA !== bytes[got]) begin failures++; $display("FAIL dout_rx%0d got=%h exp=%h", got, RX_DATA, bytes[got]); end
        got++;
      end
      tick(1);
    end
    checks++; if (got != 2) begin failures++; $display("FAIL dout_rx_count got=%0d exp=2", got); end
    tick(3);
    RX_READY = 1'b0;
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL dout_aux_int got=%h exp=80", d); end
    reg_rd(5'h17, d);
    checks++; if (d !== 8'h16) begin failures++; $display("FAIL dout_status got=%h exp=16", d); end
  endtask

  task automatic test_boundaries();
    logic [7:0] d;
    logic doe;
    reg_wr(5'h12, 8'h00);
    reg_wr(5'h13, 8'h00);
    reg_wr(5'h14, 8'h00);
    reg_wr(5'h18, 8'h20);
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL bnd_tc0_aux got=%h exp=80", d); end
    reg_rd(5'h17, d);
    checks++; if (d !== 8'h16) begin failures++; $display("FAIL bnd_tc0_status got=%h exp=16", d); end

    reg_wr(5'h14, 8'h20);
    reg_wr(5'h18, 8'h20);
    TX_VALID = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (TX_READY !== 1'b1) begin failures++; $display("FAIL bnd_fill_ready%0d got=%b exp=1", i, TX_READY); end
      TX_DATA = 8'(i);
      tick(1);
    end
    checks++; if (TX_READY !== 1'b0) begin failures++; $display("FAIL bnd_full_ready got=%b exp=0", TX_READY); end
    TX_VALID = 1'b0;
    checks++; if (DREQ_ !== 1'b0) begin failures++; $display("FAIL bnd_full_dreq got=%b exp=0", DREQ_); end

    reg_wr(5'h18, 8'h21);
    reg_rd(5'h17, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL bnd_busy_status got=%h exp=05", d); end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL bnd_busy_aux got=%h exp=03", d); end

    reg_wr(5'h05, 8'h5A);
    bus_write(1'b0, 1'b0, 8'h05);
    SCSI_CS = 1'b1; A0 = 1'b1; DIN = 8'h77; RE = 1'b1; WE = 1'b1;
    tick(2);
    RE = 1'b0; WE = 1'b0;
    tick(3);
    SCSI_CS = 1'b0; A0 = 1'b0;
    tick(1);
    bus_read(1'b0, 1'b1, d, doe);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL bnd_rewe_reg got=%h exp=5a", d); end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL bnd_rewe_aux got=%h exp=03", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic doe;
    do_reset();
    reg_wr(5'h12, 8'h00);
    reg_wr(5'h13, 8'h00);
    reg_wr(5'h14, 8'h03);
    reg_wr(5'h18, 8'h20);
    TX_VALID = 1'b1; TX_DATA = 8'h11; tick(1);
    TX_DATA = 8'h22; tick(1);
    TX_VALID = 1'b0;
    bus_read(1'b1, 1'b0, d, doe);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL rst_first_byte got=%h exp=11", d); end
    do_reset();
    checks++; if (DREQ_ !== 1'b1) begin failures++; $display("FAIL rst_dreq got=%b exp=1", DREQ_); end
    checks++; if (TX_READY !== 1'b0) begin failures++; $display("FAIL rst_tx_ready got=%b exp=0", TX_READY); end
    bus_read(1'b0, 1'b0, d, doe);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_aux got=%h exp=00", d); end
    for (int i = 0; i < 3; i++) begin
      reg_rd(5'(8'h12 + i), d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL rst_tc_reg%0d got=%h exp=00", i, d); end
    end
    reg_wr(5'h14, 8'h01);
    reg_wr(5'h18, 8'h20);
    checks++; if (DREQ_ !== 1'b1) begin failures++; $display("FAIL rst_fifo_empty_dreq got=%b exp=1", DREQ_); end
    bus_read(1'b1, 1'b0, d, doe);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL rst_empty_read got=%h exp=ff", d); end
  endtask

  initial begin
    test_reset();
    test_reg_io();
    test_dma_in();
    test_dma_out();
    test_boundaries();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
